// File: rtl/pipelined_shift_if.sv
// pipelined_shift_if
//   Operand/result handshake bundle for the pipelined barrel shifter.
//   master : producer/consumer side (drives in_valid/op/a/b and out_ready)
//   slave  : shifter side (drives in_ready, out_valid, result)
//   Signals:
//     in_valid/in_ready   input handshake
//     op[2:0]             0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR
//     a[XLEN-1:0]         value to shift
//     b[XLEN-1:0]         shift amount (low log2(XLEN) bits used)
//     out_valid/out_ready output handshake
//     result[XLEN-1:0]    shifted value
interface pipelined_shift_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/pipelined_shift.sv
// pipelined_shift
//   Elastic, pipelined barrel shifter: SLL, SRL, SRA and (optionally) ROL/ROR
//   over XLEN = 32/64/128. The log2(XLEN) shift levels are spread across
//   STAGES register stages, ceil(SW/STAGES) levels per stage.
//   Optional feature macro: SHIFT_ROTATE_EN (enables ROL/ROR; when undefined
//   op 3 acts as SLL and op 4 as SRL and no rotate muxes are built).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     flush  synchronous; kills every in-flight operation
//     bus    pipelined_shift_if.slave (in/out valid-ready handshakes)
module pipelined_shift #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2
) (
    input logic                clk,
    input logic                rst_n,
    input logic                flush,
    pipelined_shift_if.slave   bus
);
    localparam int SW = $clog2(XLEN);
    localparam int L  = (SW + STAGES - 1) / STAGES;

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
`ifdef SHIFT_ROTATE_EN
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;
`endif

    // Fold unknown / disabled codes onto the base ops once, at entry, so the
    // downstream stages only ever see legal encodings.
    function automatic logic [2:0] norm_op(input logic [2:0] o);
        case (o)
            3'd1:    return OP_SRL;
            3'd2:    return OP_SRA;
`ifdef SHIFT_ROTATE_EN
            3'd3:    return OP_ROL;
            3'd4:    return OP_ROR;
`else
            3'd4:    return OP_SRL;
`endif
            default: return OP_SLL;
        endcase
    endfunction

    function automatic logic is_left(input logic [2:0] o);
`ifdef SHIFT_ROTATE_EN
        return (o == OP_SLL) || (o == OP_ROL);
`else
        return (o == OP_SLL);
`endif
    endfunction

    function automatic logic [XLEN-1:0] rev(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) r[i] = x[XLEN-1-i];
        return r;
    endfunction

    // One right-shift level by 2^lvl. Left ops arrive bit-reversed, so only
    // right-direction hardware exists.
    function automatic logic [XLEN-1:0] lvl_shift(input logic [XLEN-1:0] x,
                                                  input int unsigned lvl,
                                                  input logic [2:0] o);
        int unsigned sh;
        sh = 32'd1 << lvl;
        case (o)
            OP_SRA:  return XLEN'($signed(x) >>> sh);
`ifdef SHIFT_ROTATE_EN
            OP_ROL,
            OP_ROR:  return (x >> sh) | (x << (XLEN - sh));
`endif
            default: return x >> sh;
        endcase
    endfunction

    logic [STAGES-1:0]           vld_pipe;
    logic [STAGES-1:0][XLEN-1:0] data_q;
    logic [STAGES-1:0][SW-1:0]   amt_q;
    logic [STAGES-1:0][2:0]      op_q;
    logic [STAGES-1:0]           load;

    // A stage loads if it or anything downstream of it is empty, or the
    // consumer takes the result this cycle. Written flat (no recursion) so the
    // ready chain is a pure function of out_ready and the valid bits.
    for (genvar k = 0; k < STAGES; k++) begin : g_load
        assign load[k] = bus.out_ready || !(&vld_pipe[STAGES-1:k]);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic            s_vld;
        logic [XLEN-1:0] s_data;
        logic [XLEN-1:0] s_out;
        logic [SW-1:0]   s_amt;
        logic [2:0]      s_op;
        logic [L-1:0]    s_bits;

        logic            v_q;
        logic [XLEN-1:0] d_q;
        logic [SW-1:0]   m_q;
        logic [2:0]      o_q;

        if (k == 0) begin : g_src
            assign s_vld  = bus.in_valid;
            assign s_op   = norm_op(bus.op);
            assign s_data = is_left(s_op) ? rev(bus.a) : bus.a;
            assign s_amt  = bus.b[SW-1:0];
        end else begin : g_src
            assign s_vld  = vld_pipe[k-1];
            assign s_op   = op_q[k-1];
            assign s_data = data_q[k-1];
            assign s_amt  = amt_q[k-1];
        end

        // Amount bits owned by this stage; slots past SW (short last stage)
        // are tied off so they pass the value through.
        for (genvar j = 0; j < L; j++) begin : g_bit
            if (k * L + j < SW) begin : g_on
                assign s_bits[j] = s_amt[k*L+j];
            end else begin : g_off
                assign s_bits[j] = 1'b0;
            end
        end

        always_comb begin
            s_out = s_data;
            for (int j = 0; j < L; j++)
                if (s_bits[j]) s_out = lvl_shift(s_out, k * L + j, s_op);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                d_q <= '0;
                m_q <= '0;
                o_q <= OP_SLL;
            end else begin
                if (flush)        v_q <= 1'b0;
                else if (load[k]) v_q <= s_vld;
                // Payload only moves with a real operation; flush need not
                // scrub it because the valid bit is what matters.
                if (load[k] && s_vld) begin
                    d_q <= s_out;
                    m_q <= s_amt;
                    o_q <= s_op;
                end
            end
        end

        assign vld_pipe[k] = v_q;
        assign data_q[k]   = d_q;
        assign amt_q[k]    = m_q;
        assign op_q[k]     = o_q;
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = vld_pipe[STAGES-1];
    // Undo the entry reversal for left ops; reset state (0, SLL) yields 0.
    assign bus.result    = is_left(op_q[STAGES-1]) ? rev(data_q[STAGES-1])
                                                   : data_q[STAGES-1];

    // Upper amount bits are ignored by definition; the last stage's amount
    // copy has no consumer.
    logic unused_bits;
    assign unused_bits = ^{bus.b[XLEN-1:SW], amt_q[STAGES-1]};
endmodule

// File: doc/pipelined_shift.md
# pipelined_shift

Pipelined, parametrised barrel shifter with valid/ready handshakes on both sides. It covers logical left, logical right, arithmetic right and, optionally, rotate, over XLEN of 32, 64 or 128. The log2(XLEN) shift levels are split across STAGES register stages so the shifter can close timing in the execute stage of wider cores. It sits between the ALU operand mux and the writeback mux, and accepts one operation per cycle when not back-pressured.

## Interface
- XLEN, 32, operand and result width; legal values 32, 64, 128.
- STAGES, 2, number of register stages; legal 1..SW, where SW = log2(XLEN) (5, 6 or 7).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; invalidates every in-flight operation.
- in_valid  in  1  operation presented.
- in_ready  out  1  stage 0 can accept this cycle.
- op  in  3  0 = SLL, 1 = SRL, 2 = SRA, 3 = ROL, 4 = ROR; other codes are treated as SLL.
- a  in  XLEN  value to shift.
- b  in  XLEN  shift amount; only b[SW-1:0] is used, upper bits are ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  shifted value.

## Operation
- Levels per stage: L = ceil(SW/STAGES).
  - Stage k applies shift levels i = k·L .. min((k+1)·L, SW)−1.
  - Level i shifts by 2^i when amount bit i is set, otherwise passes the value through.
  - The last stage may hold fewer levels.
- Each stage register holds: valid, data[XLEN], amount[SW], op[3]. The register is placed after the stage's combinational levels.
- Left ops (SLL, ROL) are performed as right ops on the bit-reversed operand; the result is reversed back after the final level.
  - Bit reversal is pure wiring and costs no cycle.
  - Bit reversal is applied in the stage 0 combinational path and after the final level.
- Right fill per level:
  - SRL shifts in zeros.
  - SRA shifts in copies of a[XLEN-1].
  - ROR/ROL shift in the bits shifted out, i.e. {x[2^i−1:0], x[XLEN−1:2^i]}.
- Amount 0 returns a unchanged for every op.
- Elastic pipeline:
  - Stage k loads when stage k is empty or stage k is advancing this cycle.
  - The last stage advances when out_valid && out_ready.
  - in_ready = stage 0 loads this cycle. in_ready is combinational from out_ready through the chain; no bubble is required between back-to-back operations.
- Transfer rules:
  - An input transfer occurs on in_valid && in_ready.
  - An output transfer occurs on out_valid && out_ready.
  - While out_valid=1 && out_ready=0, result and out_valid hold stable.
- Flush:
  - Clears all stage valid bits at the next edge.
  - The input presented in the same cycle is dropped.
  - in_ready=1 in the cycle after the flush.
  - Data registers need not clear.
- Reset (any time, including mid-operation):
  - All valid bits 0; out_valid=0, result=0, in_ready=1.
  - In-flight operations are lost and are not replayed.

## Timing
- Latency: STAGES cycles from input transfer to out_valid, with out_ready held high.
- Throughput: 1 op/cycle with out_ready=1.
- Full pipeline + out_ready=0:
  - in_ready=0.
  - No stage changes; a held input is not lost.
- Full pipeline + out_ready=1 + in_valid=1: simultaneous retire and accept, occupancy unchanged.
- Order: results leave in input order; no reordering, no skipping.
- Simultaneous flush and output transfer: the output transfer completes; everything behind it is flushed.

## Configuration
- SHIFT_ROTATE_EN defined:
  - op 3/4 perform ROL/ROR as above.
  - Rotate-mux logic is present in every level.
- SHIFT_ROTATE_EN undefined:
  - op 3 behaves as SLL and op 4 as SRL.
  - No rotate logic is synthesised.
  - Latency and handshake are unchanged.

## Test plan
- XLEN=32, STAGES=2, out_ready=1; SRA a=0x8000_0010, b=4 → result 0xF800_0001 exactly 2 cycles after the transfer, out_valid for one cycle.
- Back-to-back: SLL a=1 with b=0..31 on consecutive cycles, out_ready=1 → 32 consecutive results 1<<n in order, in_ready constantly 1; b=0x25 gives a shift of 5 (upper bits ignored).
- Back-pressure: fill pipeline, hold out_ready=0 for 5 cycles → in_ready=0, result and out_valid stable; release → all results drained in order, none duplicated or lost.
- SHIFT_ROTATE_EN, XLEN=64, STAGES=3: ROR a=0x0000_0000_0000_00F1, b=4 → 0x1000_0000_0000_000F; ROL same a, b=60 → same result. Without the macro: op 4 returns 0x0000_0000_0000_000F.
- Flush with 2 ops in flight + new input in same cycle → no out_valid in the following STAGES+1 cycles; in_ready=1 the next cycle.
- Assert rst_n low mid-stream for 1 cycle asynchronously → out_valid=0 and result=0 immediately; pipeline restarts cleanly with the next SRL a=0xFFFF_FFFF, b=31 → 0x0000_0001.
